// File: rtl/pipelined_carry_adder.sv
// -----------------------------------------------------------------------------
// pipelined_carry_adder
//
// Purpose:
//   WIDTH-bit adder split into STAGES equal chunks of CW = WIDTH/STAGES bits.
//   Each chunk is added in its own pipeline stage. The carry between chunks is
//   registered. Operands are skewed into later stages and finished result
//   chunks are carried forward, so every result leaves with all of its bits
//   aligned. A valid/ready handshake with a single global advance signal
//   supports one add per cycle. A result is presented STAGES cycles after it
//   is accepted.
//
// Parameters:
//   WIDTH   operand/result width (default 16); must be divisible by STAGES
//   STAGES  number of pipeline stages, 1..WIDTH (default 4)
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand transaction valid
//   in_ready   block can accept a transaction this cycle (combinational)
//   a, b       operands (unsigned or two's complement)
//   cin        carry-in into bit 0
//   sub        (PIPELINED_CARRY_ADDER_SUB_EN only) 1 = compute a - b - cin
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   sum        result, modulo 2^WIDTH
//   cout       carry out of bit WIDTH-1 (for subtraction: 1 = no borrow)
//   ovf        signed overflow (carry into MSB XOR carry out of MSB)
//
// Optional feature:
//   Define PIPELINED_CARRY_ADDER_SUB_EN to add the 'sub' input. Subtraction
//   is folded in at the input as a + ~b + ~cin, so the pipeline only adds.
// -----------------------------------------------------------------------------
module pipelined_carry_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = WIDTH / STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_cfg
        $error("pipelined_carry_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    // The whole pipeline moves as one unit. It stalls only when a result is
    // waiting at the output and downstream refuses it.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Effective operand B and carry-in after the optional subtract inversion.
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef PIPELINED_CARRY_ADDER_SUB_EN
    assign b_eff   = sub ? ~b   : b;
    assign cin_eff = sub ? ~cin : cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // Operand bits still outstanding when a transaction enters stage k.
        // Bits [CW-1:0] of in_a/in_b are this stage's chunk.
        localparam int IW = WIDTH - k * CW;

        logic [IW-1:0]         in_a;
        logic [IW-1:0]         in_b;
        logic                  in_c;
        logic                  in_v;
        logic [CW:0]           chunk;
        logic [(k+1)*CW-1:0]   part;   // result bits [ (k+1)*CW-1 : 0 ]

        if (k == 0) begin : g_src
            assign in_a = a;
            assign in_b = b_eff;
            assign in_c = cin_eff;
            assign in_v = in_valid;
            assign part = chunk[CW-1:0];
        end else begin : g_src
            assign in_a = g_stage[k-1].g_pipe.a_q;
            assign in_b = g_stage[k-1].g_pipe.b_q;
            assign in_c = g_stage[k-1].g_pipe.c_q;
            assign in_v = g_stage[k-1].g_pipe.v_q;
            assign part = {chunk[CW-1:0], g_stage[k-1].g_pipe.s_q};
        end

        // CW+1-bit chunk add: bit CW is the chunk carry-out.
        assign chunk = {1'b0, in_a[CW-1:0]} + {1'b0, in_b[CW-1:0]} + (CW+1)'(in_c);

        if (k < STAGES - 1) begin : g_pipe
            logic [IW-CW-1:0]      a_q;
            logic [IW-CW-1:0]      b_q;
            logic [(k+1)*CW-1:0]   s_q;
            logic                  c_q;
            logic                  v_q;

            // NOTE: sequential state is always assigned with <= so every
            // register samples the pre-edge values of its neighbours.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                end else if (adv) begin
                    v_q <= in_v;
                end
            end

            // NOTE: datapath registers carry no reset; the valid bit beside
            // them decides whether their contents mean anything.
            always_ff @(posedge clk) begin
                if (adv) begin
                    a_q <= in_a[IW-1:CW];
                    b_q <= in_b[IW-1:CW];
                    s_q <= part;
                    c_q <= chunk[CW];
                end
            end
        end else begin : g_last
            // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
            logic msb_cin;
            assign msb_cin = in_a[CW-1] ^ in_b[CW-1] ^ chunk[CW-1];

            // Visible outputs are reset so nothing stale shows after rst.
            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    sum       <= '0;
                    cout      <= 1'b0;
                    ovf       <= 1'b0;
                end else if (adv) begin
                    out_valid <= in_v;
                    sum       <= part;
                    cout      <= chunk[CW];
                    ovf       <= msb_cin ^ chunk[CW];
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_carry_adder.sv
`timescale 1ns/1ps
module tb_pipelined_carry_adder;

    localparam int W = 16;
    localparam int S = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub_v;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    // Extra single-stage and fully-pipelined builds, always draining.
    logic         iv_s1,  ir_s1,  ov_s1,  co_s1,  of_s1;
    logic         iv_s16, ir_s16, ov_s16, co_s16, of_s16;
    logic [W-1:0] s_s1, s_s16;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    pipelined_carry_adder #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
        .sub(sub_v),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    pipelined_carry_adder #(.WIDTH(W), .STAGES(1)) u_s1 (
        .clk(clk), .rst(rst), .in_valid(iv_s1), .in_ready(ir_s1),
        .a(a), .b(b), .cin(cin),
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(ov_s1), .out_ready(1'b1),
        .sum(s_s1), .cout(co_s1), .ovf(of_s1)
    );

    pipelined_carry_adder #(.WIDTH(W), .STAGES(16)) u_s16 (
        .clk(clk), .rst(rst), .in_valid(iv_s16), .in_ready(ir_s16),
        .a(a), .b(b), .cin(cin),
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(ov_s16), .out_ready(1'b1),
        .sum(s_s16), .cout(co_s16), .ovf(of_s16)
    );

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-word arithmetic reference: no chunking, no pipeline detail.
    function automatic res_t model_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic ci, input logic s);
        logic [W:0]   t;
        logic [W-1:0] yy;
        logic         cc;
        res_t         r;
        yy     = s ? ~y : y;
        cc     = s ? ~ci : ci;
        t      = {1'b0, x} + {1'b0, yy} + (W+1)'(cc);
        r.sum  = t[W-1:0];
        r.cout = t[W];
        r.ovf  = (x[W-1] == yy[W-1]) && (r.sum[W-1] != x[W-1]);
        return r;
    endfunction

    // Behavioural pipeline: S result slots that shift together on advance.
    bit   mv [S];
    res_t mr [S];

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < S; k++) mv[k] = 1'b0;
        end else if (!mv[S-1] || out_ready) begin
            for (int k = S - 1; k > 0; k--) begin
                mv[k] = mv[k-1];
                mr[k] = mr[k-1];
            end
            mv[0] = in_valid;
            mr[0] = model_add(a, b, cin, sub_v);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", W'(in_ready), W'(!mv[S-1] || out_ready));
            check("out_valid", W'(out_valid), W'(mv[S-1]));
            if (mv[S-1]) begin
                check("sum", {1'b0, sum}, {1'b0, mr[S-1].sum});
                check("cout", W'(cout), W'(mr[S-1].cout));
                check("ovf", W'(ovf), W'(mr[S-1].ovf));
            end
        end
    end

    task automatic pin(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic s,
                       input logic [W-1:0] es, input logic ec, input logic eo);
        res_t r;
        r = model_add(x, y, ci, s);
        check({name, ".sum"}, {1'b0, r.sum}, {1'b0, es});
        check({name, ".cout"}, W'(r.cout), W'(ec));
        check({name, ".ovf"}, W'(r.ovf), W'(eo));
    endtask

    // One transaction through the main DUT into an empty pipeline.
    task automatic run_one(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic tc, input logic ts,
                           input logic [W-1:0] es, input logic ec, input logic eo);
        int n;
        bit acc;
        bit seen;
        a = ta; b = tb; cin = tc; sub_v = ts; in_valid = 1'b1; out_ready = 1'b1;
        acc = 1'b0; n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        check({name, ".accepted"}, W'(acc), W'(1));
        n = 0; seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            seen = out_valid;
        end
        check({name, ".latency"}, W'(n), W'(S));
        check({name, ".sum"}, {1'b0, sum}, {1'b0, es});
        check({name, ".cout"}, W'(cout), W'(ec));
        check({name, ".ovf"}, W'(ovf), W'(eo));
        @(posedge clk); #1;
    endtask

    // Latency and value probe on the STAGES=1 (which=1) or STAGES=16 build.
    task automatic probe(input string name, input int which, input int exp_lat);
        int  n;
        bit  seen;
        a = 16'h1234; b = 16'h4321; cin = 1'b1; sub_v = 1'b0;
        @(negedge clk);
        check({name, ".in_ready"}, W'(which == 1 ? ir_s1 : ir_s16), W'(1));
        @(posedge clk); #1;
        if (which == 1) iv_s1 = 1'b1; else iv_s16 = 1'b1;
        @(posedge clk); #1;
        iv_s1 = 1'b0; iv_s16 = 1'b0;
        n = 0; seen = 1'b0;
        while (!seen && n < 50) begin
            @(negedge clk);
            n++;
            seen = (which == 1) ? ov_s1 : ov_s16;
        end
        check({name, ".latency"}, W'(n), W'(exp_lat));
        check({name, ".sum"}, {1'b0, (which == 1 ? s_s1 : s_s16)}, {1'b0, 16'h5556});
        check({name, ".cout"}, W'(which == 1 ? co_s1 : co_s16), W'(0));
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int           i;
        int           got;
        int           cyc;
        int           stall;
        logic [W-1:0] held;
        bit           first;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub_v = 1'b0;
        out_ready = 1'b1; iv_s1 = 1'b0; iv_s16 = 1'b0;

        // Hand-computed values that pin the reference itself.
        pin("pin.ffff_1",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        pin("pin.7fff_1",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        pin("pin.8000_2",  16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        pin("pin.1234",    16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        pin("pin.sub5_7",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        pin("pin.sub8000", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset.out_valid", W'(out_valid), W'(0));
        check("reset.sum", {1'b0, sum}, '0);
        check("reset.cout", W'(cout), W'(0));
        check("reset.ovf", W'(ovf), W'(0));
        check("reset.in_ready", W'(in_ready), W'(1));
        @(posedge clk); #1;

        // Directed carry/overflow corners.
        run_one("carry_all", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_one("ovf_pos",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_one("ovf_neg",   16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
        run_one("sub_5_7",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_one("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

        // Six back-to-back transactions with a 3-cycle stall after the first result.
        i = 0; got = 0; cyc = 0; stall = 0; first = 1'b0; held = '0;
        while ((i < 6 || got < 6) && cyc < 200) begin
            in_valid  = (i < 6);
            a         = W'(i + 1);
            b         = W'((i + 1) * 256);
            cin       = 1'(i + 1);
            sub_v     = 1'b0;
            out_ready = (stall == 0);
            @(negedge clk);
            if (stall > 0) begin
                check("stall.in_ready", W'(in_ready), W'(0));
                check("stall.out_valid", W'(out_valid), W'(1));
                if (stall == 3) held = sum;
                else check("stall.hold", {1'b0, sum}, {1'b0, held});
                stall--;
            end
            if (out_valid && out_ready) begin
                got++;
                check("order.sum", {1'b0, sum}, (W+1)'(got + 256 * got + (got & 1)));
                check("order.cout", W'(cout), W'(0));
                if (!first) begin
                    first = 1'b1;
                    stall = 3;
                end
            end
            if (in_valid && in_ready) i++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("stall.sent", W'(i), W'(6));
        check("stall.received", W'(got), W'(6));

        // Two transactions in flight, then reset: neither may surface.
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
        @(posedge clk); #1;
        a = 16'h3333; b = 16'h4444;
        @(posedge clk); #1;
        rst = 1'b1; a = 16'h5555; b = 16'h6666;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("midrst.out_valid", W'(out_valid), W'(0));
        check("midrst.sum", {1'b0, sum}, '0);
        check("midrst.cout", W'(cout), W'(0));
        check("midrst.ovf", W'(ovf), W'(0));
        check("midrst.in_ready", W'(in_ready), W'(1));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("midrst.no_stale", W'(out_valid), W'(0));
        end
        @(posedge clk); #1;
        run_one("post_rst", 16'h00F0, 16'h0F0F, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

        // Randomised traffic with backpressure, bubbles and rare resets.
        for (int t = 0; t < 2000; t++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            a         = pick();
            b         = pick();
            cin       = 1'($urandom_range(0, 1));
`ifdef PIPELINED_CARRY_ADDER_SUB_EN
            sub_v     = 1'($urandom_range(0, 1));
`endif
            rst       = ($urandom_range(0, 299) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sub_v = 1'b0;
        repeat (S + 2) @(posedge clk);
        #1;

        // Alternate pipeline depths.
        probe("stages1", 1, 1);
        probe("stages16", 16, 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
